relu_act_stream: RTL and testbench
==================================

// Module: relu_act_stream
// PURPOSE
//  Parametrised multi-lane FP16 activation stage between the MAC accumulator and the next layer's input buffer.
//  Each beat carries LANES values. Every value gets one of three functions, selected per beat:
//    - ReLU
//    - clipped ReLU, with a run-time ceiling
//    - leaky ReLU, with a power-of-two slope
//  Two-stage pipeline with valid/ready backpressure, plus a saturation event counter for range monitoring.
// PARAMETERS
//  LANES      4   values per beat
//  EXP_W      5   float exponent width (IEEE-754-style, bias 2^(EXP_W-1)-1)
//  MAN_W      10  float mantissa width; DATA_W = 1+EXP_W+MAN_W (16 by default)
//  LEAK_SHIFT 3   leaky slope = 2^-LEAK_SHIFT; must satisfy 1 <= LEAK_SHIFT < 2^EXP_W-2
//  CNT_W      16  saturation counter width
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              input beat valid
//  in_ready   out  1              block can accept a beat
//  in_data    in   LANES*DATA_W   lane i occupies bits [i*DATA_W +: DATA_W]
//  mode       in   2              0 ReLU, 1 clip, 2 leaky, 3 reserved (behaves as ReLU); sampled with the beat
//  ceiling    in   DATA_W         clip ceiling, positive float; sampled with the beat
//  out_valid  out  1              output beat valid
//  out_ready  in   1              downstream accepts the beat
//  out_data   out  LANES*DATA_W   activated lanes, same packing as in_data
//  sat_count  out  CNT_W          number of lanes clipped to the ceiling, counted at output handshake
//  sat_clr    in   1              synchronous clear of sat_count
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all registers to 0; out_valid=0, out_data=0, sat_count=0
//   - in_ready=0 while rst_n=0, and 1 from the first clk edge after release
//   - a beat in flight when reset asserts is discarded, with no partial output
//  Handshake:
//   - an input beat transfers when in_valid&&in_ready; an output beat transfers when out_valid&&out_ready
//   - out_valid, once high, must not drop and out_data must not change until the output handshake
//   - in_ready = !s1_valid || !s2_valid || out_ready; this combinational path from out_ready is permitted
//   - latency is exactly 2 cycles, input handshake to out_valid, when not stalled
//   - with out_ready held at 1 the block sustains one beat per cycle
//   - the pipeline holds two beats; no beat is lost or duplicated under any valid/ready pattern
//  Stage 1:
//   - registers in_data, mode and ceiling
//   - decodes each lane into sign, exponent and mantissa
//   - classifies each lane as zero, subnormal, normal, inf or NaN
//  Stage 2: computes each lane as follows, first matching rule wins:
//   - NaN (exp all ones, mantissa != 0) -> +0 in every mode
//   - -0 -> +0
//   - sign=0, mode=1, magnitude > ceiling -> out = ceiling; mark the lane saturated
//     - magnitude compare is unsigned on bits [DATA_W-2:0]; this covers +inf
//   - sign=0 otherwise -> passthrough
//   - sign=1, mode=2 (leaky):
//     - -inf -> -inf
//     - exp <= LEAK_SHIFT -> +0 (flush, no subnormal output)
//     - else exp -= LEAK_SHIFT, with sign and mantissa unchanged
//   - sign=1, any other mode -> +0
//  Ceiling with sign=1 or ceiling=NaN: mode 1 treats the ceiling as +0, so every positive lane clips to +0 and is marked saturated.
//  sat_count:
//   - on each output handshake, add the number of saturated lanes in that beat (0..LANES)
//   - saturates at 2^CNT_W-1 and does not wrap
//   - sat_clr has priority: it sets sat_count to 0 and drops that cycle's increment
//  Lanes are independent; no arithmetic crosses lane boundaries.
// TESTING
//  1. Stream, mode 0, LANES=4, out_ready=1:
//     - in {0xC000, 0x3C00, 0x8000, 0x7E00} -> out {0x0000, 0x3C00, 0x0000, 0x0000}, 2 cycles later
//  2. Mode 1, ceiling 0x4600 (6.0):
//     - in {0x4500, 0x4700, 0x7C00, 0x4600} -> out {0x4500, 0x4600, 0x4600, 0x4600}
//     - sat_count increments by 2
//  3. Mode 2, LEAK_SHIFT=3:
//     - in {0xC000, 0x8400, 0xFC00, 0x4400} -> out {0xB400, 0x0000, 0xFC00, 0x4400}
//  4. 20 back-to-back beats with out_ready toggled randomly:
//     - all 20 beats emerge in order, uncorrupted
//     - out_data stays stable while out_valid=1 and out_ready=0
//     - in_ready=0 only when both stages are full and out_ready=0
//  5. sat_count:
//     - preload to 2^CNT_W-2, then send a 4-lane all-clip beat -> sat_count=2^CNT_W-1
//     - assert sat_clr on an output handshake cycle -> sat_count=0
//  6. Reset mid-stream:
//     - drop rst_n with 2 beats in flight -> out_valid=0 and sat_count=0 immediately
//     - after release, the next accepted beat appears 2 cycles later

Source files
------------

// File: rtl/relu_act_stream.sv
// Multi-lane FP16 activation stage (ReLU / clipped ReLU / leaky ReLU) with a
// two-deep valid/ready pipeline and a saturating clip-event counter.
module relu_act_stream #(
  parameter int LANES      = 4,
  parameter int EXP_W      = 5,
  parameter int MAN_W      = 10,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16,
  localparam int DATA_W    = 1 + EXP_W + MAN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       ceiling,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        sat_count,
  input  logic                    sat_clr
);

  localparam int NS_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] LEAK_E   = EXP_W'(LEAK_SHIFT);
  localparam logic [1:0] MODE_CLIP  = 2'd1;
  localparam logic [1:0] MODE_LEAKY = 2'd2;

  typedef enum logic [2:0] {CL_ZERO, CL_SUB, CL_NORM, CL_INF, CL_NAN} lane_class_e;

  // Handshake: a beat moves on a stage boundary exactly when the sender's valid
  // and the receiver's ready are both high at a rising edge; a stage that holds
  // a beat keeps it (and its data) unchanged until the next stage takes it.
  logic                    ready_en_q;
  logic                    s1_valid_q, s2_valid_q;
  logic [LANES*DATA_W-1:0] s1_data_q, s2_data_q;
  logic [1:0]              s1_mode_q;
  logic [DATA_W-1:0]       s1_ceil_q, ceil_eff;
  lane_class_e             s1_class_q [LANES];
  lane_class_e             class_d [LANES];
  logic [NS_W-1:0]         s2_nsat_q, nsat_d;
  logic [LANES*DATA_W-1:0] act_d;
  logic [CNT_W-1:0]        sat_count_q, sat_count_d;
  logic [SUM_W-1:0]        sat_sum;
  logic [DATA_W-1:0]       lane_x, lane_y;
  logic [EXP_W-1:0]        lane_e;
  logic                    s1_take, s2_adv, in_hs, out_hs;

  function automatic lane_class_e classify(input logic [DATA_W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[DATA_W-2:MAN_W];
    f = x[MAN_W-1:0];
    if (e == '0) return (f == '0) ? CL_ZERO : CL_SUB;
    if (e == EXP_ONES) return (f == '0) ? CL_INF : CL_NAN;
    return CL_NORM;
  endfunction

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_take  = !s1_valid_q || s2_adv;
  assign in_ready = ready_en_q && s1_take;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;

  // A negative or NaN ceiling is folded to +0 once, at capture time.
  always_comb begin
    ceil_eff = ceiling;
    if (ceiling[DATA_W-1] || classify(ceiling) == CL_NAN) ceil_eff = '0;
    for (int i = 0; i < LANES; i++) class_d[i] = classify(in_data[i*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s1_ceil_q  <= '0;
      for (int i = 0; i < LANES; i++) s1_class_q[i] <= CL_ZERO;
    end else begin
      ready_en_q <= 1'b1;
      if (s1_take) begin
        s1_valid_q <= in_hs;
        if (in_hs) begin
          s1_data_q <= in_data;
          s1_mode_q <= mode;
          s1_ceil_q <= ceil_eff;
          for (int i = 0; i < LANES; i++) s1_class_q[i] <= class_d[i];
        end
      end
    end
  end

  always_comb begin
    act_d  = '0;
    nsat_d = '0;
    lane_x = '0;
    lane_e = '0;
    lane_y = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_x = s1_data_q[i*DATA_W +: DATA_W];
      lane_e = lane_x[DATA_W-2:MAN_W];
      lane_y = '0;
      if (s1_class_q[i] == CL_NAN || (lane_x[DATA_W-1] && s1_class_q[i] == CL_ZERO)) begin
        lane_y = '0;
      end else if (!lane_x[DATA_W-1]) begin
        // Unsigned compare of the magnitude bits also catches +inf.
        if (s1_mode_q == MODE_CLIP && lane_x[DATA_W-2:0] > s1_ceil_q[DATA_W-2:0]) begin
          lane_y = s1_ceil_q;
          nsat_d = nsat_d + NS_W'(1);
        end else begin
          lane_y = lane_x;
        end
      end else if (s1_mode_q == MODE_LEAKY) begin
        if (s1_class_q[i] == CL_INF) lane_y = lane_x;
        else if (lane_e > LEAK_E) lane_y = {1'b1, lane_e - LEAK_E, lane_x[MAN_W-1:0]};
      end
      act_d[i*DATA_W +: DATA_W] = lane_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_nsat_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= act_d;
        s2_nsat_q <= nsat_d;
      end
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    sat_sum     = {1'b0, sat_count_q} + SUM_W'(s2_nsat_q);
    if (sat_clr) sat_count_d = '0;
    else if (out_hs) sat_count_d = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count_q <= '0;
    else        sat_count_q <= sat_count_d;
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_relu_act_stream.sv
// Bench for relu_act_stream: directed vectors, randomized streaming with
// backpressure, counter saturation/clear and mid-stream reset.
module tb_relu_act_stream;

  localparam int LEAK    = 3;
  localparam int SAT_MAX = 65535;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, sat_clr;
  logic [63:0] in_data, out_data;
  logic [1:0]  mode;
  logic [15:0] ceiling, sat_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sat_model = 0;
  logic rdy_en = 1'b0;
  logic [63:0] exp_q[$];
  int nsat_q[$];
  int t_q[$];

  relu_act_stream #(.LANES(4), .EXP_W(5), .MAN_W(10), .LEAK_SHIFT(LEAK), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .ceiling(ceiling), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one FP16 lane, straight from the activation rules.
  function automatic logic [16:0] ref_lane(logic [15:0] x, logic [1:0] m, logic [15:0] c);
    int e, f;
    logic [15:0] cl;
    e = int'(x[14:10]);
    f = int'(x[9:0]);
    if (c[15] || (c[14:10] == 5'h1f && c[9:0] != 10'd0)) cl = 16'h0000;
    else cl = c;
    if (e == 31 && f != 0) return 17'h0;
    if (x[15] == 1'b0) begin
      if (m == 2'd1 && x[14:0] > cl[14:0]) return {1'b1, cl};
      return {1'b0, x};
    end
    if (m == 2'd2) begin
      if (e == 31) return {1'b0, x};
      if (e <= LEAK) return 17'h0;
      return {1'b0, 1'b1, 5'(e - LEAK), 10'(f)};
    end
    return 17'h0;
  endfunction

  function automatic logic [63:0] ref_beat(logic [63:0] d, logic [1:0] m, logic [15:0] c);
    logic [16:0] r;
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      r = ref_lane(d[i*16 +: 16], m, c);
      o[i*16 +: 16] = r[15:0];
    end
    return o;
  endfunction

  function automatic int ref_nsat(logic [63:0] d, logic [1:0] m, logic [15:0] c);
    logic [16:0] r;
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      r = ref_lane(d[i*16 +: 16], m, c);
      n += int'(r[16]);
    end
    return n;
  endfunction

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 7))
      0: return 16'h7C00;
      1: return 16'hFC00;
      2: return 16'h7E01;
      3: return 16'h8000;
      4: return {1'b1, 5'($urandom_range(0, 4)), 10'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_ceil();
    case ($urandom_range(0, 5))
      0: return 16'hC000;
      1: return 16'h7E00;
      2: return 16'h7C00;
      default: return {1'b0, 15'($urandom)};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, check just after, update model, pass the posedge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic [1:0] m,
                       input logic [15:0] c, input logic ordy, input logic clr,
                       input logic [63:0] e, input int ns, output logic acc);
    logic exp_ov, ohs;
    @(negedge clk);
    in_valid = v; in_data = d; mode = m; ceiling = c; out_ready = ordy; sat_clr = clr;
    #1;
    exp_ov = (exp_q.size() != 0) && (cyc - t_q[0] >= 2);
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, rdy_en && !(exp_q.size() == 2 && !ordy));
    if (out_valid && exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
    chk("sat_count", sat_count, sat_model);
    acc = v && in_ready;
    ohs = out_valid && ordy;
    if (clr) sat_model = 0;
    else if (ohs && nsat_q.size() != 0)
      sat_model = (sat_model + nsat_q[0] > SAT_MAX) ? SAT_MAX : sat_model + nsat_q[0];
    if (ohs && exp_q.size() != 0) begin
      void'(exp_q.pop_front()); void'(nsat_q.pop_front()); void'(t_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back(e); nsat_q.push_back(ns); t_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) cycle(1'b0, '0, 2'd0, '0, 1'b1, 1'b0, '0, 0, a);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic a, pending, v;
    logic [63:0] d, all_clip;
    logic [1:0] m;
    logic [15:0] c;
    int sent;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; ceiling = '0;
    out_ready = 1'b0; sat_clr = 1'b0;
    @(posedge clk); #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_sat_count", sat_count, 16'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("release_in_ready", in_ready, 1'b0);
    @(posedge clk); rdy_en = 1'b1;

    // Directed vectors, lane 0 in the low bits.
    cycle(1'b1, {16'h7E00, 16'h8000, 16'h3C00, 16'hC000}, 2'd0, 16'h0, 1'b1, 1'b0,
          {16'h0000, 16'h0000, 16'h3C00, 16'h0000}, 0, a);
    drain();
    cycle(1'b1, {16'h4600, 16'h7C00, 16'h4700, 16'h4500}, 2'd1, 16'h4600, 1'b1, 1'b0,
          {16'h4600, 16'h4600, 16'h4600, 16'h4500}, 2, a);
    drain();
    #1 chk("clip_sat_plus2", sat_count, 16'd2);
    cycle(1'b1, {16'h4400, 16'hFC00, 16'h8400, 16'hC000}, 2'd2, 16'h0, 1'b1, 1'b0,
          {16'h4400, 16'hFC00, 16'h0000, 16'hB400}, 0, a);
    drain();

    // 20 back-to-back beats against random backpressure, then random valid too.
    sent = 0; pending = 1'b0; d = '0; m = '0; c = '0;
    for (int k = 0; k < 300 && sent < 20; k++) begin
      if (!pending) begin
        d = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
        m = 2'($urandom_range(0, 3)); c = rand_ceil(); pending = 1'b1;
      end
      cycle(1'b1, d, m, c, 1'($urandom_range(0, 1)), 1'b0, ref_beat(d, m, c), ref_nsat(d, m, c), a);
      if (a) begin pending = 1'b0; sent++; end
    end
    chk("beats_sent", sent, 20);
    drain();
    for (int k = 0; k < 80; k++) begin
      if (!pending) begin
        d = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
        m = 2'($urandom_range(0, 3)); c = rand_ceil();
      end
      v = pending ? 1'b1 : 1'($urandom_range(0, 1));
      cycle(v, d, m, c, 1'($urandom_range(0, 1)), 1'b0, ref_beat(d, m, c), ref_nsat(d, m, c), a);
      pending = v && !a;
    end
    drain();

    // Counter: clear, climb to max-1, saturate, hold, then clear on a handshake.
    all_clip = {4{16'h4000}};
    cycle(1'b0, '0, 2'd0, '0, 1'b1, 1'b1, '0, 0, a);
    for (int k = 0; k < 16383; k++)
      cycle(1'b1, all_clip, 2'd1, 16'h3C00, 1'b1, 1'b0, {4{16'h3C00}}, 4, a);
    cycle(1'b1, {16'h4000, 16'h4000, 16'h3800, 16'h3800}, 2'd1, 16'h3C00, 1'b1, 1'b0,
          {16'h3C00, 16'h3C00, 16'h3800, 16'h3800}, 2, a);
    drain();
    #1 chk("sat_max_minus1", sat_count, 16'hFFFE);
    cycle(1'b1, all_clip, 2'd1, 16'h3C00, 1'b1, 1'b0, {4{16'h3C00}}, 4, a);
    drain();
    #1 chk("sat_max", sat_count, 16'hFFFF);
    cycle(1'b1, all_clip, 2'd1, 16'h3C00, 1'b1, 1'b0, {4{16'h3C00}}, 4, a);
    drain();
    #1 chk("sat_no_wrap", sat_count, 16'hFFFF);
    cycle(1'b1, all_clip, 2'd1, 16'h3C00, 1'b1, 1'b0, {4{16'h3C00}}, 4, a);
    cycle(1'b0, '0, 2'd0, '0, 1'b1, 1'b0, '0, 0, a);
    cycle(1'b0, '0, 2'd0, '0, 1'b1, 1'b1, '0, 0, a);
    #1 chk("sat_clr_on_hs", sat_count, 16'h0);
    drain();

    // Mid-stream reset with two beats held in the pipeline.
    cycle(1'b1, all_clip, 2'd1, 16'h3C00, 1'b1, 1'b0, {4{16'h3C00}}, 4, a);
    drain();
    cycle(1'b1, all_clip, 2'd1, 16'h3C00, 1'b0, 1'b0, {4{16'h3C00}}, 4, a);
    cycle(1'b1, all_clip, 2'd0, 16'h0, 1'b0, 1'b0, all_clip, 0, a);
    chk("two_in_flight", exp_q.size(), 2);
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sat_count", sat_count, 16'h0);
    chk("midrst_out_data", out_data, 64'h0);
    chk("midrst_in_ready", in_ready, 1'b0);
    exp_q.delete(); nsat_q.delete(); t_q.delete(); sat_model = 0; rdy_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rerelease_in_ready", in_ready, 1'b0);
    @(posedge clk); rdy_en = 1'b1;
    d = {16'hC000, 16'h8400, 16'h3C00, 16'h4400};
    cycle(1'b1, d, 2'd2, 16'h0, 1'b1, 1'b0, ref_beat(d, 2'd2, 16'h0), 0, a);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
